// File: rtl/ppu_vram_arb_pkg.sv
// Shared PPU constants: VRAM address width, CPU access FSM encodings and the
// default renderer-grant budget before a CPU slot is forced.
package ppu_vram_arb_pkg;
  localparam int VRAM_AW        = 14;
  localparam int STARVE_MAX_DEF = 8;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_ACK  = 2'd1,
    C_DONE = 2'd2
  } cpu_st_e;
endpackage

// File: rtl/ppu_vram_arb.sv
// Single-port VRAM arbiter: the renderer has priority while rendering, with a
// bounded-starvation CPU slot; the CPU has priority otherwise. Memory latency is 1.
module ppu_vram_arb
  import ppu_vram_arb_pkg::*;
#(
  parameter int AW         = VRAM_AW,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_rendering,
  input  logic          i_rd_req,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_gnt,
  output logic          o_rd_vld,
  output logic [7:0]    o_rd_data,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [7:0]    i_cpu_wdata,
  output logic          o_cpu_ack,
  output logic [7:0]    o_cpu_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [7:0]    o_mem_wdata,
  input  logic [7:0]    i_mem_rdata
);
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  cpu_st_e    st_q;
  logic       ack_q, we_q;
  logic [7:0] rdata_q;
  logic [7:0] starve_q, starve_d;
  logic       rd_vld_q, rd_vld_d;
  logic       cpu_elig, starve_hit, cpu_win, rd_win;

  always_comb begin
    cpu_elig   = (st_q == C_IDLE) && i_cpu_req;
    starve_hit = (starve_q >= SMAX);
    cpu_win    = cpu_elig && (!i_rendering || !i_rd_req || starve_hit);
    rd_win     = i_rd_req && !cpu_win;
    rd_vld_d   = rd_win;

    starve_d = starve_q;
    if (cpu_win || !cpu_elig)      starve_d = '0;
    else if (rd_win && !starve_hit) starve_d = starve_q + 8'd1;

    o_rd_gnt    = rd_win;
    o_mem_en    = cpu_win || rd_win;
    o_mem_we    = cpu_win && i_cpu_we;
    o_mem_addr  = cpu_win ? i_cpu_addr : (rd_win ? i_rd_addr : '0);
    o_mem_wdata = (cpu_win && i_cpu_we) ? i_cpu_wdata : '0;

    o_cpu_ack   = ack_q;
    // Read data arrives during the ack cycle; pass it straight through so it
    // is visible alongside the ack, then hold the latched copy.
    o_cpu_rdata = (ack_q && !we_q) ? i_mem_rdata : rdata_q;
    o_rd_vld    = rd_vld_q;
    o_rd_data   = rd_vld_q ? i_mem_rdata : '0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      st_q    <= C_IDLE;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (st_q)
        C_IDLE: if (cpu_win) begin
          st_q  <= C_ACK;
          ack_q <= 1'b1;
          we_q  <= i_cpu_we;
        end
        C_ACK: begin
          ack_q <= 1'b0;
          if (!we_q) rdata_q <= i_mem_rdata;
          st_q  <= C_DONE;
        end
        // A still-high request is ignored here so a held write is not replayed.
        C_DONE:  if (!i_cpu_req) st_q <= C_IDLE;
        default: st_q <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      starve_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rd_vld_q <= rd_vld_d;
    end
  end
endmodule

// File: tb/tb_ppu_vram_arb.sv
// Directed scenarios plus random traffic against a cycle-level reference model
// of the arbitration rules and a behavioural VRAM.
module tb_ppu_vram_arb;
  localparam int AW = 14;
  localparam int SM = 8;

  logic          i_clk, i_rstn, i_rendering, i_rd_req, i_cpu_req, i_cpu_we;
  logic [AW-1:0] i_rd_addr, i_cpu_addr;
  logic [7:0]    i_cpu_wdata, i_mem_rdata;
  logic          o_rd_gnt, o_rd_vld, o_cpu_ack, o_mem_en, o_mem_we;
  logic [7:0]    o_rd_data, o_cpu_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;

  ppu_vram_arb #(.AW(AW), .STARVE_MAX(SM)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_rendering(i_rendering),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_gnt(o_rd_gnt),
    .o_rd_vld(o_rd_vld), .o_rd_data(o_rd_data), .i_cpu_req(i_cpu_req),
    .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata), .o_mem_en(o_mem_en),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
    if (a == 14'h2000) return 8'h5A;
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  // Behavioural VRAM driven by the DUT's memory port
  logic [7:0] vram [0:16383];
  bit         vwr  [0:16383];
  always @(posedge i_clk)
    if (o_mem_en) begin
      if (o_mem_we) begin
        vram[o_mem_addr] <= o_mem_wdata;
        vwr[o_mem_addr]  <= 1'b1;
      end else
        i_mem_rdata <= vwr[o_mem_addr] ? vram[o_mem_addr] : init_byte(o_mem_addr);
    end

  // Reference model state
  logic [7:0] ref_mem [0:16383];
  bit         ref_wr  [0:16383];
  bit         served, e_ack, e_vld;
  int         waitc;
  logic [7:0] e_rdv, e_cpu_rdata;
  int         n_chk = 0, n_fail = 0;

  bit            ob_gnt, ob_en, ob_we, ob_ack, ob_vld;
  logic [AW-1:0] ob_addr;
  logic [7:0]    ob_rdata;

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    served = 0; waitc = 0; e_ack = 0; e_vld = 0; e_rdv = '0; e_cpu_rdata = '0;
  endtask

  // One cycle: check all outputs at the falling edge, advance the model at the rising edge
  task automatic step();
    bit elig, cw, rw;
    @(negedge i_clk);
    if (!i_rstn) model_reset();
    elig = i_cpu_req && !served;
    cw   = elig && (!i_rendering || !i_rd_req || waitc >= SM);
    rw   = i_rd_req && !cw;
    chk("rd_gnt",    32'(o_rd_gnt),    32'(rw));
    chk("mem_en",    32'(o_mem_en),    32'(cw || rw));
    chk("mem_we",    32'(o_mem_we),    32'(cw && i_cpu_we));
    chk("mem_addr",  32'(o_mem_addr),  32'(cw ? i_cpu_addr : (rw ? i_rd_addr : 14'h0)));
    chk("mem_wdata", 32'(o_mem_wdata), 32'((cw && i_cpu_we) ? i_cpu_wdata : 8'h0));
    chk("cpu_ack",   32'(o_cpu_ack),   32'(e_ack));
    chk("cpu_rdata", 32'(o_cpu_rdata), 32'(e_cpu_rdata));
    chk("rd_vld",    32'(o_rd_vld),    32'(e_vld));
    chk("rd_data",   32'(o_rd_data),   32'(e_vld ? e_rdv : 8'h0));
    ob_gnt = o_rd_gnt; ob_en = o_mem_en; ob_we = o_mem_we; ob_ack = o_cpu_ack;
    ob_vld = o_rd_vld; ob_addr = o_mem_addr; ob_rdata = o_cpu_rdata;
    @(posedge i_clk);
    if (!i_rstn) model_reset();
    else begin
      if (cw && !i_cpu_we) e_cpu_rdata = ref_rd(i_cpu_addr);
      if (cw && i_cpu_we) begin ref_mem[i_cpu_addr] = i_cpu_wdata; ref_wr[i_cpu_addr] = 1; end
      e_vld = rw;
      if (rw) e_rdv = ref_rd(i_rd_addr);
      if (served && !e_ack && !i_cpu_req) served = 0;
      e_ack = cw;
      if (cw) served = 1;
      if (cw || !elig) waitc = 0;
      else if (rw)     waitc = (waitc < SM) ? waitc + 1 : SM;
    end
    #1;
  endtask

  // Steps until a CPU access is issued; reports how many renderer grants preceded it
  task automatic run_to_cpu(input string tag, output int rg);
    bit hit = 0;
    rg = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      step();
      if (ob_en && !ob_gnt) hit = 1;
      else if (ob_gnt) rg++;
    end
    chk({tag, "_cpu_granted"}, 32'(hit), 32'(1));
  endtask

  initial begin
    int rg, cnt, cnt2;
    bit cpu_on, acked;
    i_rstn = 0; i_rendering = 0; i_rd_req = 0; i_rd_addr = '0;
    i_cpu_req = 0; i_cpu_we = 0; i_cpu_addr = '0; i_cpu_wdata = '0;
    model_reset();
    #2;
    step(); step();
    chk("reset_ack", 32'(ob_ack), 32'(0));
    i_rstn = 1;
    step();

    // Vblank CPU read while the renderer also requests
    i_rendering = 0; i_rd_req = 1; i_rd_addr = 14'h0100;
    i_cpu_req = 1; i_cpu_we = 0; i_cpu_addr = 14'h2000;
    step();
    chk("A_grant_addr", 32'(ob_addr), 32'(14'h2000));
    chk("A_rd_blocked", 32'(ob_gnt), 32'(0));
    step();
    chk("A_ack", 32'(ob_ack), 32'(1));
    chk("A_rdata", 32'(ob_rdata), 32'(8'h5A));
    chk("A_rd_gnt", 32'(ob_gnt), 32'(1));
    i_cpu_req = 0; i_rd_req = 0;
    step(); step();

    // Renderer stream, no CPU
    i_rendering = 1; cnt = 0; cnt2 = 0;
    for (int i = 0; i < 16; i++) begin
      i_rd_req = 1; i_rd_addr = 14'(i);
      step(); cnt += int'(ob_gnt); cnt2 += int'(ob_vld);
    end
    i_rd_req = 0;
    step(); cnt2 += int'(ob_vld);
    chk("B_grants", 32'(cnt), 32'(16));
    chk("B_valids", 32'(cnt2), 32'(16));

    // Starvation escape with a CPU write, then a held request
    i_rd_req = 1; i_rd_addr = 14'h0040;
    i_cpu_req = 1; i_cpu_we = 1; i_cpu_addr = 14'h3F00; i_cpu_wdata = 8'h21;
    run_to_cpu("C", rg);
    chk("C_rd_grants", 32'(rg), 32'(SM));
    chk("C_we", 32'(ob_we), 32'(1));
    chk("C_addr", 32'(ob_addr), 32'(14'h3F00));
    cnt = 1;
    step();
    chk("C_ack", 32'(ob_ack), 32'(1));
    for (int i = 0; i < 4; i++) begin step(); cnt += int'(ob_we); end
    chk("D_single_write", 32'(cnt), 32'(1));
    i_cpu_req = 0;
    step(); step();
    i_cpu_req = 1; i_cpu_we = 0;
    run_to_cpu("D2", rg);
    step();
    chk("D2_ack", 32'(ob_ack), 32'(1));
    chk("D2_readback", 32'(ob_rdata), 32'(8'h21));
    i_cpu_req = 0; i_rd_req = 0;
    step(); step();

    // Reset in the cycle after a CPU grant
    i_rendering = 0; i_cpu_req = 1; i_cpu_we = 0; i_cpu_addr = 14'h0123;
    step();
    i_rstn = 0;
    step();
    chk("E_ack_dropped", 32'(ob_ack), 32'(0));
    chk("E_rdata_clear", 32'(ob_rdata), 32'(0));
    i_rstn = 1;
    step();
    chk("E_regrant", 32'(ob_en && !ob_gnt && ob_addr == 14'h0123), 32'(1));
    step();
    i_cpu_req = 0;
    step(); step();

    // Mode switch releases a CPU waiting behind the renderer
    i_rendering = 1; i_rd_req = 1; i_rd_addr = 14'h0300;
    i_cpu_req = 1; i_cpu_we = 0; i_cpu_addr = 14'h0200;
    step(); step(); step();
    chk("F_waiting", 32'(ob_gnt), 32'(1));
    i_rendering = 0;
    step();
    chk("F_cpu_wins", 32'(ob_en && !ob_gnt && ob_addr == 14'h0200), 32'(1));
    i_rendering = 1;
    step();
    i_cpu_req = 0;
    step(); step();
    i_cpu_req = 1; i_cpu_addr = 14'h0201;
    run_to_cpu("F2", rg);
    chk("F2_full_budget", 32'(rg), 32'(SM));
    step();
    i_cpu_req = 0; i_rd_req = 0;
    step(); step();

    // Random traffic
    cpu_on = 0; acked = 0;
    for (int i = 0; i < 400; i++) begin
      i_rendering = ($urandom_range(0, 3) != 0);
      i_rd_req    = ($urandom_range(0, 3) != 0);
      i_rd_addr   = 14'($urandom_range(0, 63));
      if (!cpu_on && $urandom_range(0, 3) == 0) begin
        cpu_on = 1; i_cpu_req = 1; i_cpu_we = 1'($urandom_range(0, 1));
        i_cpu_addr = 14'($urandom_range(0, 63)); i_cpu_wdata = 8'($urandom);
      end
      step();
      if (ob_ack) acked = 1;
      if (cpu_on && acked && $urandom_range(0, 2) == 0) begin
        cpu_on = 0; acked = 0; i_cpu_req = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ppu_vram_arb.md
Name: ppu_vram_arb

Overview:
- Arbitrates one single-port PPU VRAM between two requesters: the rendering engine's fetch port and the CPU-side PPUDATA ($2007) access port.
- The renderer has strict priority while rendering is active, with a bounded-starvation escape for the CPU. The CPU has priority during vblank or when rendering is disabled.
- Sits between the PPU register file / rendering engine and the VRAM / nametable / palette memory wrapper. The memory has a fixed 1-cycle read latency.

Parameters:
- AW, 14, VRAM address width ($0000-$3FFF).
- STARVE_MAX, 8, number of consecutive renderer grants with a CPU request pending before one CPU slot is forced; range 1..255.

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  asynchronous active-low reset
- i_rendering  in  1  1 = renderer active (bg_ena|spr_ena and not vblank); supplied by the PPU timing logic
- i_rd_req  in  1  renderer read request, single-cycle per fetch
- i_rd_addr  in  AW  renderer read address
- o_rd_gnt  out  1  renderer request accepted this cycle (combinational)
- o_rd_vld  out  1  renderer read data valid
- o_rd_data  out  8  renderer read data
- i_cpu_req  in  1  CPU access request, level, held until ack
- i_cpu_we  in  1  1 = write, 0 = read
- i_cpu_addr  in  AW  CPU address
- i_cpu_wdata  in  8  CPU write data
- o_cpu_ack  out  1  one-cycle completion pulse
- o_cpu_rdata  out  8  CPU read data, held until the next CPU read completes
- o_mem_en  out  1  memory access strobe (combinational)
- o_mem_we  out  1  memory write enable (combinational)
- o_mem_addr  out  AW  memory address (combinational)
- o_mem_wdata  out  8  memory write data (combinational)
- i_mem_rdata  in  8  memory read data, valid 1 cycle after o_mem_en

Behaviour:
- Reset (async assert, sync release): all registered outputs are 0, the CPU FSM is in C_IDLE, and the starve counter is 0.
- One memory access per cycle at most. Combinational outputs are 0 when no access is issued.

CPU FSM:
- C_IDLE: the CPU is eligible when i_cpu_req=1. On CPU grant, go to C_ACK.
- C_ACK: o_cpu_ack=1 for exactly this cycle.
  - If the access was a read, latch i_mem_rdata into o_cpu_rdata.
  - Go to C_DONE.
- C_DONE: wait for i_cpu_req=0, then go to C_IDLE.
- A CPU request still high in C_ACK or C_DONE is never re-granted; this prevents duplicate writes.
- CPU latency from first eligible cycle is 1 cycle when the CPU wins immediately, plus any cycles lost to renderer priority.

Arbitration (per cycle, CPU eligible only in C_IDLE with i_cpu_req=1):
- i_rendering=1:
  - The renderer wins if i_rd_req=1 and starve_cnt<STARVE_MAX.
  - The CPU wins if it is eligible and either i_rd_req=0 or starve_cnt==STARVE_MAX.
  - When the forced CPU slot is taken, o_rd_gnt=0; the renderer must hold or retry its request.
- i_rendering=0:
  - The CPU wins whenever it is eligible.
  - The renderer wins otherwise.

Starve counter (8-bit, saturating at STARVE_MAX):
- Increments on each renderer grant while the CPU is eligible.
- Clears on CPU grant, or whenever the CPU is not eligible.

Renderer data path:
- o_rd_vld is o_rd_gnt registered (1-cycle delay).
- o_rd_data equals i_mem_rdata when o_rd_vld=1, and 0 otherwise.
- Back-to-back grants give a full-throughput stream with 1-cycle latency.

Other rules:
- A change of i_rendering takes effect in the same cycle's arbitration. There is no state change except starve_cnt rules.
- CPU writes drive o_mem_we=1 with i_cpu_wdata. The renderer path never writes.
- Address wrap and mirroring are out of scope; the address is passed through unmodified.
- Reset mid-access: the pending ack and o_rd_vld are dropped. The CPU must re-request after reset.

Decomposition:
- Shared PPU package holds:
  - VRAM_AW=14;
  - CPU FSM state encodings C_IDLE=2'd0, C_ACK=2'd1, C_DONE=2'd2;
  - STARVE_MAX default.
- No sub-module; the starve counter and FSM fit inline.

Test Plan:
- Vblank CPU read: i_rendering=0, CPU reads $2000 holding $5A while the renderer also requests.
  - CPU is granted at T: o_mem_addr=$2000, o_rd_gnt=0.
  - o_cpu_ack=1 at T+1 with o_cpu_rdata=$5A.
  - The renderer is granted at T+1.
- Rendering stream, no CPU: i_rd_req=1 for 16 cycles over addresses $0000-$000F.
  - o_rd_gnt=1 on all 16 cycles.
  - o_rd_vld follows 1 cycle later with the matching data.
- Starvation escape: i_rendering=1, continuous i_rd_req, CPU write $3F00←$21, STARVE_MAX=8.
  - Exactly 8 renderer grants, then 1 cycle with o_mem_we=1 at addr $3F00, data $21, o_rd_gnt=0.
  - ack follows the next cycle.
- No double write: CPU holds i_cpu_req for 4 cycles after ack.
  - Exactly one o_mem_we pulse.
  - A new request after req falls is granted normally.
- Mid-operation reset: assert i_rstn=0 in the cycle after a CPU grant.
  - o_cpu_ack, o_rd_vld and o_cpu_rdata are 0; FSM is in C_IDLE.
  - After release with i_cpu_req=1, a fresh grant is issued.
- Mode switch: i_rendering toggles 1→0 while the CPU is pending behind the renderer.
  - The CPU wins in the same cycle i_rendering=0.
  - starve_cnt clears after the CPU grant.
